uart_rx_word_packer: RTL and testbench
======================================

Name: uart_rx_word_packer

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte-done strobe and byte data.
- Frames bytes into fixed-width words using the packet format: SYNC byte, WORD_BYTES payload bytes (little-endian), one XOR checksum byte.
- Presents each validated word on a valid/ready interface to the core. Reports checksum, timeout and overrun errors as single-cycle pulses.

Parameters:
- DATA_WIDTH, 8, width of one UART byte; matches the receiver.
- WORD_BYTES, 4, payload bytes per word (legal range 1..8).
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT_TICKS, 2560, tick count with no accepted byte that aborts a partial packet (16 frames at 16x oversampling).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  16x baud oversampling strobe; the same strobe the receiver uses.
- rx_done  in  1  receiver byte-complete flag; may stay high for several cycles.
- rx_data  in  DATA_WIDTH  receiver byte; valid when rx_done is high.
- word_data  out  WORD_BYTES*DATA_WIDTH  assembled word.
- word_valid  out  1  word_data holds an unconsumed, checksum-valid word.
- word_ready  in  1  consumer accepts word_data.
- chk_err  out  1  one-cycle pulse when the checksum mismatches.
- timeout_err  out  1  one-cycle pulse when a partial packet is aborted.
- overrun_err  out  1  one-cycle pulse for each byte dropped while a word is pending.
- busy  out  1  high whenever state is not HUNT.

Behaviour:
- Reset: rst is sampled on the clk edge. Reset drives:
  - state to HUNT;
  - word_data, word_valid, all error pulses and busy to 0;
  - byte count, checksum and timeout counter to 0;
  - the rx_done edge register to 0.
- Reset mid-packet discards all partial data, with no error pulse.
- Byte event: exactly one per rising edge of rx_done (rx_done=1 and the registered previous rx_done=0). rx_data is sampled in that cycle. rx_done held high for N cycles produces one event.
- HUNT:
  - On an event with rx_data==SYNC_BYTE, go to PAYLOAD, with count=0 and checksum=0.
  - Any other byte is discarded silently.
- PAYLOAD:
  - On each event, write the byte into internal assembly register slice [count*8 +: 8]; the first byte goes to the LSBs.
  - checksum ^= byte; count++.
  - The event that delivers payload byte WORD_BYTES goes to CHECK.
  - A payload byte equal to SYNC_BYTE is ordinary data; the block does not resync.
- CHECK:
  - On an event with rx_data==checksum: copy the assembly register to word_data, set word_valid=1 in the next cycle, go to HOLD. Latency is checksum event at cycle N, word_valid at N+1.
  - On mismatch: pulse chk_err in cycle N+1, go to HUNT. word_data is unchanged.
- HOLD:
  - word_valid=1. word_data stays stable until word_valid&&word_ready is true at a clk edge.
  - After that edge, word_valid=0 and state is HUNT.
  - Any byte event in HOLD (including SYNC) is dropped and pulses overrun_err in the next cycle.
  - The consumer may hold word_ready high continuously; the word is then consumed one cycle after word_valid rises.
- Timeout:
  - Only in PAYLOAD and CHECK, the counter increments on each tick and clears on each byte event.
  - When the counter reaches TIMEOUT_TICKS: pulse timeout_err in the next cycle, go to HUNT, discard the partial word.
  - If a byte event coincides with the terminal tick, the byte wins: it is processed and the counter clears, with no timeout.
  - The counter is held at 0 in HUNT and HOLD.
- Error pulses are registered and exactly one cycle wide. Different error pulses are mutually exclusive within a cycle.
- word_data keeps the last delivered word outside HOLD.
- busy=1 in PAYLOAD, CHECK and HOLD.

Test Plan:
- Good packet: A5 11 22 33 44 44, with word_ready=1 -> word_data=32'h44332211, word_valid high for exactly 1 cycle, starting 1 cycle after the checksum event; no error pulses.
- Bad checksum: A5 11 22 33 44 45 -> chk_err one pulse, no word_valid, busy=0. Then the good packet again -> 32'h44332211 delivered.
- Garbage before sync: 00 FF 5A, then the good packet -> only 32'h44332211 delivered, no errors. Payload A5 A5 A5 A5 with checksum 00 -> word 32'hA5A5A5A5.
- Backpressure: word_ready=0 after the first good packet, then bytes A5 01 -> two overrun_err pulses, word_data stays 32'h44332211. Raise word_ready -> word_valid drops the next cycle, busy=0.
- Timeout: A5 11 22, then no bytes for 2560 ticks -> timeout_err pulse after the 2560th tick, busy=0. Repeat with a byte event on the 2560th tick -> no timeout.
- Edge/reset: rx_done held high 5 cycles per byte -> one event per byte, packet decodes to 32'h44332211. Assert rst after A5 11 -> all outputs 0, next full packet decodes correctly.

Source files
------------

// File: rtl/uart_rx_word_packer.sv
// Frames UART receiver bytes into SYNC + little-endian payload + XOR checksum
// packets and hands each validated word to the core over valid/ready.
module uart_rx_word_packer #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    WORD_BYTES    = 4,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = 8'hA5,
    parameter int                    TIMEOUT_TICKS = 2560
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tick,
    input  logic                             rx_done,
    input  logic [DATA_WIDTH-1:0]            rx_data,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] word_data,
    output logic                             word_valid,
    input  logic                             word_ready,
    output logic                             chk_err,
    output logic                             timeout_err,
    output logic                             overrun_err,
    output logic                             busy
);

    localparam int WW = WORD_BYTES * DATA_WIDTH;
    localparam int CW = $clog2(WORD_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(WORD_BYTES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK,
        HOLD
    } state_t;

    state_t                  state, state_n;
    logic                    rx_done_q;
    logic [CW-1:0]           count, count_n;
    logic [DATA_WIDTH-1:0]   checksum, checksum_n;
    logic [WW-1:0]           assembly, assembly_n;
    logic [WW-1:0]           word_data_n;
    logic [TW-1:0]           timer, timer_n;
    logic                    chk_err_n, timeout_err_n, overrun_err_n;
    logic                    byte_event;

    // A long rx_done level counts as a single byte: only its rising edge matters.
    assign byte_event = rx_done && !rx_done_q;
    assign word_valid = (state == HOLD);
    assign busy       = (state != HUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            rx_done_q   <= 1'b0;
            count       <= '0;
            checksum    <= '0;
            assembly    <= '0;
            word_data   <= '0;
            timer       <= '0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_n;
            rx_done_q   <= rx_done;
            count       <= count_n;
            checksum    <= checksum_n;
            assembly    <= assembly_n;
            word_data   <= word_data_n;
            timer       <= timer_n;
            chk_err     <= chk_err_n;
            timeout_err <= timeout_err_n;
            overrun_err <= overrun_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        count_n       = count;
        checksum_n    = checksum;
        assembly_n    = assembly;
        word_data_n   = word_data;
        timer_n       = '0;
        chk_err_n     = 1'b0;
        timeout_err_n = 1'b0;
        overrun_err_n = 1'b0;

        case (state)
            HUNT: begin
                if (byte_event && rx_data == SYNC_BYTE) begin
                    state_n    = PAYLOAD;
                    count_n    = '0;
                    checksum_n = '0;
                end
            end
            PAYLOAD: begin
                if (byte_event) begin
                    for (int i = 0; i < WORD_BYTES; i++) begin
                        if (count == CW'(i)) begin
                            assembly_n[i*DATA_WIDTH +: DATA_WIDTH] = rx_data;
                        end
                    end
                    checksum_n = checksum ^ rx_data;
                    count_n    = count + 1'b1;
                    if (count == COUNT_LAST) begin
                        state_n = CHECK;
                    end
                end
            end
            CHECK: begin
                if (byte_event) begin
                    if (rx_data == checksum) begin
                        word_data_n = assembly;
                        state_n     = HOLD;
                    end else begin
                        chk_err_n = 1'b1;
                        state_n   = HUNT;
                    end
                end
            end
            HOLD: begin
                if (word_ready) begin
                    state_n = HUNT;
                end
                if (byte_event) begin
                    overrun_err_n = 1'b1;
                end
            end
            default: state_n = HUNT;
        endcase

        // A byte arriving on the terminal tick keeps the packet alive.
        if ((state == PAYLOAD || state == CHECK) && !byte_event) begin
            if (tick) begin
                if (timer == TIMER_LAST) begin
                    state_n       = HUNT;
                    timeout_err_n = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end else begin
                timer_n = timer;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed and randomized checks of uart_rx_word_packer against a packet-level
// reference model (packed word and XOR checksum computed from the byte list).
module tb_uart_rx_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        chk_err;
    logic        timeout_err;
    logic        overrun_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int chk_cnt = 0;
    int to_cnt  = 0;
    int ovr_cnt = 0;
    logic [31:0] got_words [$];
    logic [31:0] exp_words [$];

    logic        s1_valid, s1_chk, s1_to, s1_ovr, s1_busy;
    logic [31:0] s1_data;
    logic        s2_valid, s2_chk, s2_ovr, s2_busy;

    uart_rx_word_packer #(
        .DATA_WIDTH   (8),
        .WORD_BYTES   (4),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_TICKS(2560)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .chk_err    (chk_err),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters and delivered-word capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_err)     chk_cnt++;
        if (timeout_err) to_cnt++;
        if (overrun_err) ovr_cnt++;
        if (word_valid && word_ready) got_words.push_back(word_data);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] model_word(input logic [7:0] b [4]);
        logic [31:0] w = 0;
        for (int i = 3; i >= 0; i--) w = w * 256 + 32'(b[i]);
        return w;
    endfunction

    function automatic logic [7:0] model_chk(input logic [7:0] b [4]);
        logic [7:0] c = 0;
        for (int i = 0; i < 4; i++) c = c ^ b[i];
        return c;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One byte with rx_done held for 'hold' cycles; snapshots after the event
    // edge (s1) and the edge after that (s2).
    task automatic applyStimulus(input logic [7:0] b, input int hold);
        rx_data = b;
        rx_done = 1'b1;
        cycle();
        s1_valid = word_valid; s1_data = word_data; s1_chk = chk_err;
        s1_to = timeout_err; s1_ovr = overrun_err; s1_busy = busy;
        if (hold <= 1) rx_done = 1'b0;
        cycle();
        s2_valid = word_valid; s2_chk = chk_err; s2_ovr = overrun_err; s2_busy = busy;
        for (int i = 2; i < hold; i++) cycle();
        rx_done = 1'b0;
        cycle();
    endtask

    task automatic send_packet(input logic [7:0] b [4], input logic [7:0] ck, input int hold);
        applyStimulus(8'hA5, hold);
        for (int i = 0; i < 4; i++) applyStimulus(b[i], hold);
        applyStimulus(ck, hold);
    endtask

    initial begin
        logic [7:0] good_pl [4];
        logic [7:0] sync_pl [4];
        logic [7:0] pl [4];
        int c0, t0, o0;

        good_pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        sync_pl = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
        rst = 1'b1; tick = 1'b0; rx_done = 1'b0; rx_data = 8'h00; word_ready = 1'b1;
        cycle();
        cycle();
        checkOutput("reset_valid", word_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_data", word_data, 0);
        checkOutput("reset_errs", {chk_err, timeout_err, overrun_err}, 0);
        rst = 1'b0;
        cycle();

        $display("[TB] good packet");
        c0 = chk_cnt; t0 = to_cnt; o0 = ovr_cnt;
        send_packet(good_pl, model_chk(good_pl), 1);
        exp_words.push_back(32'h44332211);
        checkOutput("good_valid_n1", s1_valid, 1);
        checkOutput("good_data", s1_data, 32'h44332211);
        checkOutput("good_valid_n2", s2_valid, 0);
        checkOutput("good_busy_after", s2_busy, 0);
        checkOutput("good_no_errs", (chk_cnt - c0) + (to_cnt - t0) + (ovr_cnt - o0), 0);

        $display("[TB] bad checksum");
        c0 = chk_cnt;
        send_packet(good_pl, 8'h45, 1);
        checkOutput("bad_chk_pulse", s1_chk, 1);
        checkOutput("bad_chk_width", s2_chk, 0);
        checkOutput("bad_chk_count", chk_cnt - c0, 1);
        checkOutput("bad_no_valid", s1_valid, 0);
        checkOutput("bad_busy", s1_busy, 0);
        checkOutput("bad_data_kept", word_data, 32'h44332211);
        send_packet(good_pl, 8'h44, 1);
        exp_words.push_back(32'h44332211);
        checkOutput("after_bad_data", s1_data, 32'h44332211);

        $display("[TB] garbage and sync-valued payload");
        c0 = chk_cnt;
        applyStimulus(8'h00, 1);
        applyStimulus(8'hFF, 1);
        applyStimulus(8'h5A, 1);
        checkOutput("garbage_busy", busy, 0);
        send_packet(good_pl, 8'h44, 1);
        exp_words.push_back(32'h44332211);
        checkOutput("garbage_good_valid", s1_valid, 1);
        send_packet(sync_pl, model_chk(sync_pl), 1);
        exp_words.push_back(32'hA5A5A5A5);
        checkOutput("sync_payload_data", s1_data, 32'hA5A5A5A5);
        checkOutput("garbage_no_chk", chk_cnt - c0, 0);

        $display("[TB] backpressure");
        word_ready = 1'b0;
        send_packet(good_pl, 8'h44, 1);
        exp_words.push_back(32'h44332211);
        o0 = ovr_cnt;
        applyStimulus(8'hA5, 1);
        checkOutput("ovr_pulse1", s1_ovr, 1);
        checkOutput("ovr_width", s2_ovr, 0);
        applyStimulus(8'h01, 1);
        checkOutput("ovr_pulse2", s1_ovr, 1);
        checkOutput("ovr_count", ovr_cnt - o0, 2);
        checkOutput("bp_valid_held", word_valid, 1);
        checkOutput("bp_data_held", word_data, 32'h44332211);
        word_ready = 1'b1;
        cycle();
        checkOutput("bp_valid_drop", word_valid, 0);
        checkOutput("bp_busy_drop", busy, 0);

        $display("[TB] timeout");
        t0 = to_cnt;
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h11, 1);
        applyStimulus(8'h22, 1);
        for (int k = 1; k < 2560; k++) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
        checkOutput("to_not_yet", to_cnt - t0, 0);
        checkOutput("to_busy_before", busy, 1);
        tick = 1'b1; cycle();
        tick = 1'b0;
        checkOutput("to_pulse", timeout_err, 1);
        checkOutput("to_busy_after", busy, 0);
        cycle();
        checkOutput("to_width", timeout_err, 0);

        t0 = to_cnt;
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h11, 1);
        applyStimulus(8'h22, 1);
        for (int k = 1; k < 2560; k++) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
        tick = 1'b1; rx_done = 1'b1; rx_data = 8'h33;
        cycle();
        tick = 1'b0; rx_done = 1'b0;
        checkOutput("to_byte_wins_busy", busy, 1);
        cycle();
        applyStimulus(8'h44, 1);
        applyStimulus(8'h44, 1);
        exp_words.push_back(32'h44332211);
        checkOutput("to_byte_wins_data", s1_data, 32'h44332211);
        checkOutput("to_byte_wins_none", to_cnt - t0, 0);

        $display("[TB] long rx_done and reset");
        send_packet(good_pl, 8'h44, 5);
        exp_words.push_back(32'h44332211);
        checkOutput("hold5_valid", s1_valid, 1);
        checkOutput("hold5_data", s1_data, 32'h44332211);
        c0 = chk_cnt; t0 = to_cnt; o0 = ovr_cnt;
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h11, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_data", word_data, 0);
        checkOutput("rst_mid_valid", word_valid, 0);
        cycle();
        send_packet(good_pl, 8'h44, 1);
        exp_words.push_back(32'h44332211);
        checkOutput("rst_then_good", s1_data, 32'h44332211);
        checkOutput("rst_no_errs", (chk_cnt - c0) + (to_cnt - t0) + (ovr_cnt - o0), 0);

        $display("[TB] randomized packets");
        for (int p = 0; p < 8; p++) begin
            logic [7:0] g;
            logic [7:0] ck;
            int ng;
            bit good;
            ng = $urandom_range(0, 2);
            for (int n = 0; n < ng; n++) begin
                do g = 8'($urandom); while (g == 8'hA5);
                applyStimulus(g, 1);
            end
            for (int i = 0; i < 4; i++) pl[i] = 8'($urandom);
            good = 1'($urandom_range(0, 1));
            ck = model_chk(pl);
            if (!good) ck = ck ^ 8'($urandom_range(1, 255));
            word_ready = 1'($urandom_range(0, 1));
            c0 = chk_cnt;
            send_packet(pl, ck, $urandom_range(1, 3));
            if (good) begin
                exp_words.push_back(model_word(pl));
                checkOutput("rand_valid", s1_valid, 1);
                checkOutput("rand_data", s1_data, model_word(pl));
                if (!word_ready) begin
                    checkOutput("rand_held", word_valid, 1);
                    word_ready = 1'b1;
                    cycle();
                end
                checkOutput("rand_consumed", word_valid, 0);
            end else begin
                checkOutput("rand_chk_err", chk_cnt - c0, 1);
                checkOutput("rand_no_valid", s1_valid, 0);
            end
            word_ready = 1'b1;
        end

        cycle();
        checkOutput("word_count", got_words.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < got_words.size(); i++) begin
            checkOutput("word_stream", got_words[i], exp_words[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
